decrypter_out: RTL and testbench

Output side of the decryption path: collects 32-bit plaintext words from FastModExp and serializes them onto the UART transmitter byte interface. Frame format is the same one the UART receive path accepts: a 4-byte length header (word count), then each word as 4 bytes, MSB first. A one-word holding register absorbs a result that arrives while the previous word is still being transmitted.

---
 rtl/decrypter_out_pkg.sv | 20 ++
 rtl/decrypter_out.sv | 139 +++++++++++++
 tb/tb_decrypter_out.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypter_out_pkg.sv
// Shared frame constants and FSM encoding for the decryption output path.
// The UART receive/load path uses the same constants, so the frame format is defined once.
package decrypter_out_pkg;

    localparam int unsigned WordW        = 32;
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned ByteW        = 8;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StSend     = 3'd1;
    localparam logic [2:0] StGuard    = 3'd2;
    localparam logic [2:0] StWaitTx   = 3'd3;
    localparam logic [2:0] StWaitWord = 3'd4;

    // Drop the byte just sent; frames go out MSB first.
    function automatic logic [WordW-1:0] shift_byte(input logic [WordW-1:0] w);
        return {w[WordW-ByteW-1:0], {ByteW{1'b0}}};
    endfunction

endpackage

// File: rtl/decrypter_out.sv
// Serializes a length header plus FastModExp result words onto the UART byte interface,
// with a one-word holding register for results that arrive mid-transmission.
module decrypter_out
    import decrypter_out_pkg::*;
#(
    parameter int unsigned WORD_W = WordW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] msg_len,
    input  logic              fme_done,
    input  logic [WORD_W-1:0] fme_data_out,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] words_sent_q, words_sent_d;
    logic              is_header_q, is_header_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              load_hold;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        len_d        = len_q;
        words_sent_d = words_sent_q;
        is_header_d  = is_header_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        tx_start     = 1'b0;
        load_hold    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d        = msg_len;
                    shreg_d      = msg_len;
                    byte_cnt_d   = 2'd0;
                    words_sent_d = '0;
                    is_header_d  = 1'b1;
                    overflow_d   = 1'b0;
                    hold_valid_d = 1'b0;
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = StGuard;
                end
            end
            // tx_busy only rises the cycle after tx_start, so it is not trusted here.
            StGuard: state_d = StWaitTx;
            StWaitTx: begin
                if (!tx_busy) begin
                    if (byte_cnt_q != 2'(BytesPerWord - 1)) begin
                        shreg_d    = shift_byte(shreg_q);
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = StSend;
                    end else if (words_sent_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitWord;
                    end
                end
            end
            StWaitWord: begin
                if (hold_valid_q) begin
                    load_hold    = 1'b1;
                    shreg_d      = hold_q;
                    byte_cnt_d   = 2'd0;
                    is_header_d  = 1'b0;
                    words_sent_d = words_sent_q + WORD_W'(1);
                    hold_valid_d = 1'b0;
                    state_d      = StSend;
                end
            end
            default: state_d = StIdle;
        endcase

        // A word loaded this cycle frees the hold, so a same-cycle result is captured.
        if (state_q != StIdle && fme_done) begin
            if (words_sent_q == len_q || (hold_valid_q && !load_hold)) begin
                overflow_d = 1'b1;
            end else begin
                hold_d       = fme_data_out;
                hold_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            byte_cnt_q   <= 2'd0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            len_q        <= '0;
            words_sent_q <= '0;
            is_header_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            len_q        <= len_d;
            words_sent_q <= words_sent_d;
            is_header_q  <= is_header_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tx_data  = shreg_q[WORD_W-1 -: 8];
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_decrypter_out.sv
// Scoreboard bench for decrypter_out: stimulus pushes expected bytes, a monitor pops on tx_start.
module tb_decrypter_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] msg_len;
    logic        fme_done;
    logic [31:0] fme_data_out;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        overflow;

    decrypter_out #(.WORD_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .msg_len      (msg_len),
        .fme_done     (fme_done),
        .fme_data_out (fme_data_out),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_tx      = 0;
    int n_done    = 0;
    int u_cnt     = 0;
    int stuck_idx = -1;
    logic [7:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Byte monitor / scoreboard
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_tx++;
            check("tx_start_while_busy", 32'(tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_byte", 32'(tx_data), -1);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        if (done === 1'b1) begin
            n_done++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    // UART transmitter model: busy from the cycle after tx_start for a random time
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                int dur;
                dur = (u_cnt == stuck_idx) ? 50 : int'($urandom_range(1, 4));
                u_cnt++;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (dur) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic pulse_start(input logic [31:0] len);
        start   = 1'b1;
        msg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic pulse_fme(input logic [31:0] d);
        fme_done     = 1'b1;
        fme_data_out = d;
        tick();
        fme_done     = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int c = 0;
        while (n_tx < n && c < 3000) begin
            tick();
            c++;
        end
        if (n_tx < n) fail_now(name, n_tx, n);
    endtask

    task automatic wait_uart_idle();
        int c = 0;
        while (tx_busy && c < 200) begin
            tick();
            c++;
        end
        tick();
        tick();
    endtask

    // Opens a frame: expected header, start pulse, first-byte timing
    task automatic open_frame(input logic [31:0] len, output int base, output int d0);
        wait_uart_idle();
        base = n_tx;
        d0   = n_done;
        push_word(len);
        pulse_start(len);
        check("first_tx_start", 32'(tx_start), 32'd1);
        check("first_tx_data", 32'(tx_data), 32'(len[31:24]));
        check("busy_in_frame", 32'(busy), 32'd1);
        check("ovf_cleared", 32'(overflow), 32'd0);
    endtask

    task automatic close_frame(input string name, input int d0, input logic exp_ovf);
        int c = 0;
        while (n_done == d0 && c < 5000) begin
            tick();
            c++;
        end
        if (n_done == d0) fail_now({name, "_done_timeout"}, n_done - d0, 1);
        repeat (3) tick();
        check({name, "_done_count"}, 32'(n_done - d0), 32'd1);
        check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Random words, each issued once the previous word has begun transmitting
    task automatic frame_rand(input logic [31:0] len, input string name);
        int base, d0;
        logic [31:0] w;
        open_frame(len, base, d0);
        for (int k = 0; k < int'(len); k++) begin
            wait_tx(base + 4 * k + 1, {name, "_wait_word"});
            repeat ($urandom_range(0, 8)) tick();
            w = $urandom;
            push_word(w);
            pulse_fme(w);
        end
        close_frame(name, d0, 1'b0);
    endtask

    initial begin
        int base, d0;
        logic [31:0] w;
        rst          = 1'b1;
        start        = 1'b0;
        msg_len      = '0;
        fme_done     = 1'b0;
        fme_data_out = '0;
        repeat (3) tick();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Empty message: header only
        open_frame(32'd0, base, d0);
        close_frame("len0", d0, 1'b0);

        // Two words, each after the previous one drained
        open_frame(32'd2, base, d0);
        wait_tx(base + 4, "len2_hdr");
        wait_uart_idle();
        push_word(32'hDEAD_BEEF);
        pulse_fme(32'hDEAD_BEEF);
        wait_tx(base + 8, "len2_w0");
        wait_uart_idle();
        push_word(32'h0102_0304);
        pulse_fme(32'h0102_0304);
        close_frame("len2", d0, 1'b0);

        // Result arriving in WAIT_WORD goes out two cycles later
        open_frame(32'd1, base, d0);
        wait_tx(base + 4, "ww_hdr");
        wait_uart_idle();
        w = 32'hA5C3_0F96;
        push_word(w);
        pulse_fme(w);
        check("ww_no_early_tx", 32'(tx_start), 32'd0);
        tick();
        check("ww_tx_start", 32'(tx_start), 32'd1);
        check("ww_tx_data", 32'(tx_data), 32'hA5);
        close_frame("ww", d0, 1'b0);

        // Back-to-back: second word held, third dropped
        open_frame(32'd2, base, d0);
        wait_tx(base + 1, "b2b_hdr");
        push_word(32'h1111_2222);
        pulse_fme(32'h1111_2222);
        wait_tx(base + 6, "b2b_byte1");
        push_word(32'h3333_4444);
        pulse_fme(32'h3333_4444);
        pulse_fme(32'h5555_6666);
        tick();
        check("b2b_overflow_set", 32'(overflow), 32'd1);
        close_frame("b2b", d0, 1'b1);

        // UART stuck busy on byte 2
        stuck_idx = u_cnt + 2;
        frame_rand(32'd1, "stuck");
        stuck_idx = -1;

        // Reset during header byte 2, then a clean frame
        open_frame(32'd3, base, d0);
        wait_tx(base + 3, "rst_hdr");
        rst = 1'b1;
        #1;
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        frame_rand(32'd1, "after_rst");

        // start while busy is ignored; fme_done in idle is ignored
        open_frame(32'd1, base, d0);
        wait_tx(base + 2, "ign_hdr");
        start   = 1'b1;
        msg_len = 32'h00FF_00FF;
        tick();
        start   = 1'b0;
        wait_tx(base + 4, "ign_hdr_end");
        w = 32'h7E57_1D1E;
        push_word(w);
        pulse_fme(w);
        close_frame("ign", d0, 1'b0);
        pulse_fme(32'hBAD0_BAD0);
        repeat (4) tick();
        check("idle_fme_overflow", 32'(overflow), 32'd0);
        check("idle_fme_busy", 32'(busy), 32'd0);

        // Result after the last word was loaded is an overflow
        open_frame(32'd1, base, d0);
        wait_tx(base + 1, "late_hdr");
        w = 32'hCAFE_F00D;
        push_word(w);
        pulse_fme(w);
        wait_tx(base + 5, "late_w0");
        pulse_fme(32'h0BAD_0BAD);
        tick();
        check("late_overflow", 32'(overflow), 32'd1);
        close_frame("late", d0, 1'b1);

        for (int f = 0; f < 10; f++) frame_rand(32'($urandom_range(0, 5)), "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
